// File: rtl/rr_arb_mux.sv
// N-channel valid/ready arbitrating mux: round-robin or fixed-priority grant,
// one-hot AND-OR payload select, optional registered output stage.
module rr_arb_mux #(
   parameter type         T         = logic,
   parameter int unsigned SEL_WIDTH = 4,
   parameter int unsigned PRIO_MODE = 0,
   parameter int unsigned OUT_REG   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  T                     data_i [SEL_WIDTH-1:0],
   input  logic [SEL_WIDTH-1:0] valid_i,
   output logic [SEL_WIDTH-1:0] ready_o,
   output T                     data_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [SEL_WIDTH-1:0] grant_o
);

   localparam int unsigned DW    = $bits(T);
   localparam int unsigned PTR_W = (SEL_WIDTH > 1) ? $clog2(SEL_WIDTH) : 1;

   logic [PTR_W-1:0]       r_ptr;
   logic [2*SEL_WIDTH-1:0] w_req_dbl;
   logic [SEL_WIDTH-1:0]   w_req_rot;
   logic [SEL_WIDTH-1:0]   w_gnt_rot;
   logic [2*SEL_WIDTH-1:0] w_gnt_dbl;
   logic [SEL_WIDTH-1:0]   w_gnt;
   logic [DW-1:0]          w_mux;
   logic [SEL_WIDTH-1:0]   w_acc;
   logic [PTR_W-1:0]       w_acc_idx;
   logic [PTR_W-1:0]       w_ptr_nxt;

   // Rotate requests so r_ptr sits at bit 0, isolate the lowest set bit, rotate back.
   // In fixed-priority mode r_ptr stays 0, so this reduces to lowest-index-wins.
   always_comb begin
      w_req_dbl = {valid_i, valid_i} >> r_ptr;
      w_req_rot = w_req_dbl[SEL_WIDTH-1:0];
      w_gnt_rot = w_req_rot & (~w_req_rot + SEL_WIDTH'(1));
      w_gnt_dbl = {w_gnt_rot, w_gnt_rot} << r_ptr;
      w_gnt     = w_gnt_dbl[2*SEL_WIDTH-1:SEL_WIDTH];
   end

   // One-hot AND-OR payload select; zero when nothing is granted.
   always_comb begin
      w_mux = '0;
      for (int i = 0; i < int'(SEL_WIDTH); i++) begin
         w_mux = w_mux | (DW'(data_i[i]) & {DW{w_gnt[i]}});
      end
   end

   assign w_acc = ready_o & valid_i;

   always_comb begin
      w_acc_idx = '0;
      for (int i = 0; i < int'(SEL_WIDTH); i++) begin
         if (w_acc[i]) begin
            w_acc_idx = PTR_W'(i);
         end
      end
      w_ptr_nxt = (w_acc_idx == PTR_W'(SEL_WIDTH - 1)) ? '0 : w_acc_idx + PTR_W'(1);
   end

   // Pointer only moves on an accepted transfer, so a stalled request keeps its grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if ((PRIO_MODE == 0) && (|w_acc)) begin
         r_ptr <= w_ptr_nxt;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic                 w_load_en;
         logic                 r_valid;
         T                     r_data;
         logic [SEL_WIDTH-1:0] r_grant;

         assign w_load_en = !r_valid | ready_i;
         assign ready_o   = w_gnt & {SEL_WIDTH{w_load_en}};

         always_ff @(posedge clk) begin
            if (rst) begin
               r_valid <= 1'b0;
               r_data  <= '0;
               r_grant <= '0;
            end else if (w_load_en) begin
               r_valid <= |valid_i;
               r_data  <= T'(w_mux);
               r_grant <= w_gnt;
            end
         end

         assign valid_o = r_valid;
         assign data_o  = r_data;
         assign grant_o = r_grant;
      end else begin : g_comb
         assign ready_o = w_gnt & {SEL_WIDTH{ready_i}};
         assign valid_o = |valid_i;
         assign data_o  = T'(w_mux);
         assign grant_o = w_gnt;
      end
   endgenerate

`ifdef COMM_ASSERT
   a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(ready_o));
   a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_o));
   a_stall_hold:   assert property (@(posedge clk) disable iff (rst)
                      (valid_o && !ready_i) |=> (valid_o && $stable(data_o)));
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed table-driven bench for rr_arb_mux: round-robin/registered,
// fixed-priority/registered and round-robin/combinational instances.
module tb_rr_arb_mux;

   localparam int unsigned N  = 4;
   localparam int          NV = 23;

   typedef logic [7:0] byte_t;

   typedef struct {
      int unsigned dut;        // 0 = rr/reg, 1 = fixed/reg, 2 = rr/comb
      logic [3:0]  valid;
      logic        ready;
      logic [3:0]  exp_ready;  // sampled before the edge
      logic        exp_valid;  // after the edge (reg) or before it (comb)
      logic [7:0]  exp_data;
      logic [3:0]  exp_grant;
   } vec_t;

   logic  clk = 1'b0;
   logic  rst;
   byte_t d_rr [N-1:0];
   byte_t d_cb [N-1:0];

   logic [3:0] v_rr, v_fp, v_cb;
   logic       rd_rr, rd_fp, rd_cb;
   logic [3:0] ro_rr, ro_fp, ro_cb;
   byte_t      do_rr, do_fp, do_cb;
   logic       vo_rr, vo_fp, vo_cb;
   logic [3:0] go_rr, go_fp, go_cb;

   logic [3:0] s_ready;
   logic       s_valid;
   byte_t      s_data;
   logic [3:0] s_grant;

   int n_checks = 0;
   int n_errors = 0;
   vec_t vecs [NV];

   always #5 clk = ~clk;

   rr_arb_mux #(.T(byte_t), .SEL_WIDTH(N), .PRIO_MODE(0), .OUT_REG(1)) u_rr (
      .clk(clk), .rst(rst), .data_i(d_rr), .valid_i(v_rr), .ready_o(ro_rr),
      .data_o(do_rr), .valid_o(vo_rr), .ready_i(rd_rr), .grant_o(go_rr));

   rr_arb_mux #(.T(byte_t), .SEL_WIDTH(N), .PRIO_MODE(1), .OUT_REG(1)) u_fp (
      .clk(clk), .rst(rst), .data_i(d_rr), .valid_i(v_fp), .ready_o(ro_fp),
      .data_o(do_fp), .valid_o(vo_fp), .ready_i(rd_fp), .grant_o(go_fp));

   rr_arb_mux #(.T(byte_t), .SEL_WIDTH(N), .PRIO_MODE(0), .OUT_REG(0)) u_cb (
      .clk(clk), .rst(rst), .data_i(d_cb), .valid_i(v_cb), .ready_o(ro_cb),
      .data_o(do_cb), .valid_o(vo_cb), .ready_i(rd_cb), .grant_o(go_cb));

   task automatic check(input string name, input int idx,
                        input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s (step %0d): got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic sample(input int unsigned dut);
      case (dut)
         0: begin s_ready = ro_rr; s_valid = vo_rr; s_data = do_rr; s_grant = go_rr; end
         1: begin s_ready = ro_fp; s_valid = vo_fp; s_data = do_fp; s_grant = go_fp; end
         default: begin s_ready = ro_cb; s_valid = vo_cb; s_data = do_cb; s_grant = go_cb; end
      endcase
   endtask

   task automatic check_out(input int idx, input vec_t v);
      sample(v.dut);
      check("valid_o", idx, 32'(s_valid), 32'(v.exp_valid));
      check("data_o",  idx, 32'(s_data),  32'(v.exp_data));
      check("grant_o", idx, 32'(s_grant), 32'(v.exp_grant));
   endtask

   // Each vector starts 1 time unit after a rising edge and consumes exactly one edge.
   task automatic run_vec(input int i);
      vec_t v;
      v = vecs[i];
      v_rr = '0; v_fp = '0; v_cb = '0;
      rd_rr = 1'b1; rd_fp = 1'b1; rd_cb = 1'b1;
      case (v.dut)
         0: begin v_rr = v.valid; rd_rr = v.ready; end
         1: begin v_fp = v.valid; rd_fp = v.ready; end
         default: begin v_cb = v.valid; rd_cb = v.ready; end
      endcase
      #1;
      sample(v.dut);
      check("ready_o", i, 32'(s_ready), 32'(v.exp_ready));
      if (v.dut == 2) begin
         check_out(i, v);
         @(posedge clk); #1;
      end else begin
         @(posedge clk); #1;
         check_out(i, v);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Round-robin, registered output
      vecs[0]  = '{0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 4'b0001};
      vecs[1]  = '{0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'hA1, 4'b0010};
      vecs[2]  = '{0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA2, 4'b0100};
      vecs[3]  = '{0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'hA3, 4'b1000};
      vecs[4]  = '{0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 4'b0001};
      vecs[5]  = '{0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000};
      vecs[6]  = '{0, 4'b0110, 1'b0, 4'b0010, 1'b1, 8'hA1, 4'b0010};
      vecs[7]  = '{0, 4'b0100, 1'b0, 4'b0000, 1'b1, 8'hA1, 4'b0010};
      vecs[8]  = '{0, 4'b0100, 1'b0, 4'b0000, 1'b1, 8'hA1, 4'b0010};
      vecs[9]  = '{0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA2, 4'b0100};
      vecs[10] = '{0, 4'b0011, 1'b1, 4'b0001, 1'b1, 8'hA0, 4'b0001};
      vecs[11] = '{0, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'hA1, 4'b0010};
      vecs[12] = '{0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000};
      // Fixed priority, registered output
      vecs[13] = '{1, 4'b1001, 1'b1, 4'b0001, 1'b1, 8'hA0, 4'b0001};
      vecs[14] = '{1, 4'b1001, 1'b1, 4'b0001, 1'b1, 8'hA0, 4'b0001};
      vecs[15] = '{1, 4'b1001, 1'b1, 4'b0001, 1'b1, 8'hA0, 4'b0001};
      vecs[16] = '{1, 4'b1000, 1'b1, 4'b1000, 1'b1, 8'hA3, 4'b1000};
      vecs[17] = '{1, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000};
      // Round-robin, combinational pass-through
      vecs[18] = '{2, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'h5C, 4'b0100};
      vecs[19] = '{2, 4'b0100, 1'b0, 4'b0000, 1'b1, 8'h5C, 4'b0100};
      vecs[20] = '{2, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000};
      vecs[21] = '{2, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'h60, 4'b1000};
      vecs[22] = '{2, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h58, 4'b0010};

      for (int i = 0; i < int'(N); i++) begin
         d_rr[i] = 8'hA0 + 8'(i);
         d_cb[i] = 8'h54 + 8'(4 * i);
      end

      rst = 1'b1;
      v_rr = 4'b1111; v_fp = '0; v_cb = '0;
      rd_rr = 1'b1; rd_fp = 1'b1; rd_cb = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("rst valid_o", -1, 32'(vo_rr), 32'd0);
      check("rst data_o",  -1, 32'(do_rr), 32'd0);
      check("rst grant_o", -1, 32'(go_rr), 32'd0);
      check("rst fp valid_o", -1, 32'(vo_fp), 32'd0);
      @(negedge clk);
      @(posedge clk); #1;
      // Re-align: the release cycle above already consumed one edge with valid_i=1111,
      // loading channel 0; confirm that, then clear the output before the table.
      check("first grant_o", -1, 32'(go_rr), 32'b0001);
      check("first data_o",  -1, 32'(do_rr), 32'hA0);
      v_rr = '0;
      @(posedge clk); #1;
      check("drain valid_o", -1, 32'(vo_rr), 32'd0);
      // Pointer now 1: restart the table from a clean pointer via reset.
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         run_vec(i);
      end

      // Reset mid-operation discards held output and returns the pointer to 0.
      v_rr = 4'b0100; rd_rr = 1'b0;
      @(posedge clk); #1;
      check("mid load valid_o", -2, 32'(vo_rr), 32'd1);
      check("mid load data_o",  -2, 32'(do_rr), 32'hA2);
      rst = 1'b1; v_rr = '0;
      @(posedge clk); #1;
      check("mid rst valid_o", -3, 32'(vo_rr), 32'd0);
      check("mid rst data_o",  -3, 32'(do_rr), 32'd0);
      check("mid rst grant_o", -3, 32'(go_rr), 32'd0);
      rst = 1'b0; v_rr = 4'b1001; rd_rr = 1'b1;
      #1;
      check("ptr after rst ready_o", -4, 32'(ro_rr), 32'b0001);
      @(posedge clk); #1;
      check("ptr after rst data_o", -4, 32'(do_rr), 32'hA0);
      v_rr = '0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
N-channel arbitrating multiplexer with valid/ready handshakes on every input and on the output. It picks one requesting channel per transfer, using round-robin or fixed priority. The selected payload goes through an internal one-hot AND-OR mux of user type T, and an optional output register stage sits after it. It is used wherever several producers share one downstream consumer, for example result write-back or shared bus request paths.

Parameters:
T, logic, payload data type (any packed type; width = $bits(T))
SEL_WIDTH, 4, number of input channels (>=1)
PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
OUT_REG, 1, 1 = registered output stage (1-cycle latency), 0 = combinational pass-through (0 latency)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, synchronous, active-high
data_i  input  T [SEL_WIDTH-1:0]  per-channel payload (unpacked array)
valid_i  input  SEL_WIDTH  per-channel request valid
ready_o  output  SEL_WIDTH  per-channel accept; at most one bit set per cycle
data_o  output  T  selected payload
valid_o  output  1  output valid
ready_i  input  1  downstream ready
grant_o  output  SEL_WIDTH  one-hot index of the channel whose payload is on data_o; 0 when valid_o=0

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: valid_o=0, data_o=0, grant_o=0, RR pointer=0 (channel 0 highest priority). ready_o is combinational.
- Input contract: once valid_i[i] is high, the producer holds it and data_i[i] stable until ready_o[i]=1.
- Grant: combinational one-hot vector gnt derived from valid_i.
  - PRIO_MODE=1: lowest set index wins.
  - PRIO_MODE=0: search starts at ptr and wraps modulo SEL_WIDTH; the first set index wins.
  - gnt=0 when valid_i=0.
- Mux: AND-OR one-hot select of data_i by gnt; result is 0 when gnt=0.
- OUT_REG=1:
  - load_en = !valid_o | ready_i.
  - ready_o = gnt & {SEL_WIDTH{load_en}}.
  - On a clock edge with load_en=1: valid_o <= |valid_i, data_o <= mux result, grant_o <= gnt.
  - With load_en=0 (valid_o=1, ready_i=0): data_o, valid_o and grant_o hold exactly (stall).
  - Full throughput: one transfer per cycle when ready_i stays high. ready_o never depends combinationally on valid_o of the same cycle beyond load_en.
  - When valid_i=0 and load_en=1, valid_o<=0, grant_o<=0, data_o<=0.
- OUT_REG=0:
  - valid_o = |valid_i; data_o = mux result; grant_o = gnt.
  - ready_o = gnt & {SEL_WIDTH{ready_i}}.
- Pointer (PRIO_MODE=0 only):
  - On a cycle with accepted channel k (ready_o[k] & valid_i[k]): ptr <= (k+1) mod SEL_WIDTH. Wrap-around from SEL_WIDTH-1 goes to 0.
  - Otherwise ptr holds, including during stalls, so a stalled request keeps its grant.
  - In PRIO_MODE=1 the pointer is unused and stays 0.
- ptr width is $clog2(SEL_WIDTH), minimum 1 bit. SEL_WIDTH=1 degenerates to a valid/ready register or wire with grant_o=valid_o.
- Reset mid-operation: rst wins over any load or hold. Pending output data is discarded and valid_o=0 on the next cycle. ready_o may be non-zero during rst only via combinational gnt; producers must not treat that as a transfer.
- Assertions under COMM_ASSERT:
  - $onehot0(ready_o) and $onehot0(grant_o).
  - valid_o held and data_o stable while valid_o & !ready_i.

Test Plan:
- Reset: drive rst=1 for 2 cycles with valid_i=4'b1111 -> after release first cycle valid_o=0, grant_o=0, data_o=0. The next cycle shows grant_o=4'b0001.
- Round-robin, OUT_REG=1, SEL_WIDTH=4, ready_i=1, valid_i=4'b1111 held, data_i[i]=8'hA0+i -> data_o sequence A0,A1,A2,A3,A0 on consecutive cycles, one ready_o bit per cycle.
- Backpressure: valid_i=4'b0110, ready_i=0 for 3 cycles then 1 -> data_o=A1/grant_o=4'b0010 held 3 cycles, ready_o=0 during the stall, then A1 and A2 are accepted and the pointer ends at 3.
- Wrap/skip: ptr=3 (after accepting ch2), valid_i=4'b0011 -> ch0 granted, then ch1.
- Fixed priority (PRIO_MODE=1), valid_i=4'b1001 held, ready_i=1 -> ch0 granted every cycle and ch3 starves. Drop valid_i[0] -> ch3 is granted the next cycle.
- OUT_REG=0, ready_i=1, valid_i=4'b0100, data_i[2]=8'h5C -> same-cycle valid_o=1, data_o=5C, ready_o=4'b0100. With ready_i=0 -> ready_o=0 and data_o still shows 5C.
